// File: rtl/periph_rd_arb_if.sv
// Bus bundle between the CPU/debug requesters, the read arbiter and the peripheral read port.
interface periph_rd_arb_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    // Requesters and peripheral side
    modport master (
        output cpu_req, cpu_addr, dbg_req, dbg_addr, mem_dout,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr, busy
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_addr, dbg_req, dbg_addr, mem_dout,
        output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr, busy
    );
endinterface

// File: rtl/periph_rd_arb.sv
// Two-requester read arbiter for a registered-read peripheral port; one read in flight,
// round-robin or CPU-priority selection.
module periph_rd_arb #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter bit          CPU_PRIO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    periph_rd_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [ADDR_W-1:0] mem_addr, mem_addr_nxt;
    logic              cpu_gnt, cpu_gnt_nxt, dbg_gnt, dbg_gnt_nxt;
    logic              cpu_rvalid, cpu_rvalid_nxt, dbg_rvalid, dbg_rvalid_nxt;
    logic [DATA_W-1:0] cpu_rdata, cpu_rdata_nxt, dbg_rdata, dbg_rdata_nxt;
    logic              busy, busy_nxt;
    logic              pick_dbg_c;

    // Owner doubles as last_owner; reset to DBG so the CPU wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_DBG;
            mem_addr   <= '0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            mem_addr   <= mem_addr_nxt;
            cpu_gnt    <= cpu_gnt_nxt;
            dbg_gnt    <= dbg_gnt_nxt;
            cpu_rvalid <= cpu_rvalid_nxt;
            dbg_rvalid <= dbg_rvalid_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            dbg_rdata  <= dbg_rdata_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        mem_addr_nxt   = mem_addr;
        cpu_gnt_nxt    = 1'b0;
        dbg_gnt_nxt    = 1'b0;
        cpu_rvalid_nxt = 1'b0;
        dbg_rvalid_nxt = 1'b0;
        cpu_rdata_nxt  = cpu_rdata;
        dbg_rdata_nxt  = dbg_rdata;
        pick_dbg_c     = bus.dbg_req && (!bus.cpu_req || (!CPU_PRIO && owner == OWN_CPU));

        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    state_nxt = ISSUE;
                    if (pick_dbg_c) begin
                        owner_nxt    = OWN_DBG;
                        mem_addr_nxt = bus.dbg_addr;
                        dbg_gnt_nxt  = 1'b1;
                    end else begin
                        owner_nxt    = OWN_CPU;
                        mem_addr_nxt = bus.cpu_addr;
                        cpu_gnt_nxt  = 1'b1;
                    end
                end
            end
            ISSUE: state_nxt = CAPTURE;
            CAPTURE: begin
                state_nxt = IDLE;
                if (owner == OWN_DBG) begin
                    dbg_rdata_nxt  = bus.mem_dout;
                    dbg_rvalid_nxt = 1'b1;
                end else begin
                    cpu_rdata_nxt  = bus.mem_dout;
                    cpu_rvalid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.mem_addr   = mem_addr;
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.cpu_rdata  = cpu_rdata;
    assign bus.dbg_rdata  = dbg_rdata;
    assign bus.busy       = busy;
endmodule
